regc_dp: RTL and testbench



---
 rtl/regc_dp.sv | 140 ++++++++++++++
 tb/tb_regc_dp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regc_dp.sv
// Dual-port coefficient register bank with hardware clear sweep, out-of-range flagging and busy status.
// Optional macro REGC_DP_BYPASS_EN selects write-first collision behaviour (default read-first).
module regc_dp #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              clr_start,
   output logic              busy,
   output logic              oob_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic [0:0]       state_reg, state_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;

   logic              wr_in_range, rd_in_range;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic              idle;
   logic              port_wr, port_rd, oob_hit, bypass_hit;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_CMP);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_CMP);
   assign wr_idx      = wr_addr[IDX_W-1:0];
   assign rd_idx      = rd_addr[IDX_W-1:0];

   // Port traffic is only honoured while the sweep is not running.
   assign idle    = (state_reg == IDLE);
   assign port_wr = idle && wr_en && wr_in_range;
   assign port_rd = idle && rd_en;
   assign oob_hit = idle && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));

`ifdef REGC_DP_BYPASS_EN
   assign bypass_hit = port_wr && rd_in_range && (rd_idx == wr_idx);
`else
   assign bypass_hit = 1'b0;
`endif

   assign busy = (state_reg == CLEAR);

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (clr_start) begin
               state_next = CLEAR;
               ptr_next   = '0;
            end
         end
         CLEAR: begin
            if (ptr_reg == LAST_IDX) begin
               state_next = IDLE;
               ptr_next   = '0;
            end else begin
               ptr_next = ptr_reg + IDX_ONE;
            end
         end
         default: begin
            state_next = CLEAR;
            ptr_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= CLEAR;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   // Single write port shared between the clear sweep and the user port.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_idx;
      mem_wdata = wr_data;
      if (!rst) begin
         if (state_reg == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_reg;
            mem_wdata = '0;
         end else if (port_wr) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Registered read; the array read sees the pre-write contents, giving read-first by default.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         oob_err  <= 1'b0;
      end else begin
         rd_valid <= port_rd;
         oob_err  <= oob_hit;
         if (port_rd) begin
            if (!rd_in_range) begin
               rd_data <= '0;
            end else if (bypass_hit) begin
               rd_data <= wr_data;
            end else begin
               rd_data <= mem[rd_idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_regc_dp.sv
// Self-checking bench for regc_dp: directed scenarios plus randomized traffic against an array model.
module tb_regc_dp;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              clr_start;
   logic              busy;
   logic              oob_err;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] model [0:DEPTH-1];
   logic [DATA_W-1:0] last_rd;

   regc_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .clr_start(clr_start), .busy(busy), .oob_err(oob_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
   endtask

   task automatic test_reset;
      int cnt;
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (busy !== 1'b1 || rd_valid !== 1'b0 || oob_err !== 1'b0 || rd_data !== 16'h0) begin
         bad++;
         $display("FAIL reset_state got busy=%b valid=%b oob=%b data=%h exp 1 0 0 0000", busy, rd_valid, oob_err, rd_data);
      end
      cnt = 1;
      for (int i = 0; i < 200 && busy === 1'b1; i++) begin
         tick();
         if (busy === 1'b1) cnt++;
      end
      total++;
      if (cnt != DEPTH || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy_len got=%0d exp=%0d", cnt, DEPTH);
      end
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      last_rd = '0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_en = 1'b1; rd_addr = ADDR_W'(a);
         tick();
         total++;
         if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_read addr=%0d got valid=%b data=%h exp 1 0000", a, rd_valid, rd_data);
         end
      end
      idle_inputs();
      tick();
      total++;
      if (rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid_drop got=%b exp=0", rd_valid);
      end
   endtask

   task automatic test_write_read;
      wr_en = 1'b1; wr_addr = 7'd5;  wr_data = 16'hA5A5; tick();
      wr_addr = 7'd63; wr_data = 16'h1234; tick();
      model[5] = 16'hA5A5; model[63] = 16'h1234;
      idle_inputs();
      rd_en = 1'b1; rd_addr = 7'd5; tick();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5) begin
         bad++;
         $display("FAIL wr_rd_5 got valid=%b data=%h exp 1 a5a5", rd_valid, rd_data);
      end
      rd_addr = 7'd63; tick();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
         bad++;
         $display("FAIL wr_rd_63 got valid=%b data=%h exp 1 1234", rd_valid, rd_data);
      end
      idle_inputs(); tick();
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 16'h1234) begin
         bad++;
         $display("FAIL wr_rd_hold got valid=%b data=%h exp 0 1234", rd_valid, rd_data);
      end
      last_rd = 16'h1234;
   endtask

   task automatic test_collision;
      logic [DATA_W-1:0] exp_first;
`ifdef REGC_DP_BYPASS_EN
      exp_first = 16'hBEEF;
`else
      exp_first = 16'h0001;
`endif
      wr_en = 1'b1; wr_addr = 7'd10; wr_data = 16'h0001; tick();
      wr_data = 16'hBEEF; rd_en = 1'b1; rd_addr = 7'd10; tick();
      model[10] = 16'hBEEF;
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_first) begin
         bad++;
         $display("FAIL collision_first got valid=%b data=%h exp 1 %h", rd_valid, rd_data, exp_first);
      end
      wr_en = 1'b0; tick();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
         bad++;
         $display("FAIL collision_second got valid=%b data=%h exp 1 beef", rd_valid, rd_data);
      end
      idle_inputs(); tick();
      last_rd = 16'hBEEF;
   endtask

   task automatic test_oob;
      wr_en = 1'b1; wr_addr = 7'd64; wr_data = 16'hFFFF;
      rd_en = 1'b1; rd_addr = 7'd100; tick();
      total++;
      if (oob_err !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
         bad++;
         $display("FAIL oob_pulse got oob=%b valid=%b data=%h exp 1 1 0000", oob_err, rd_valid, rd_data);
      end
      idle_inputs(); rd_en = 1'b1; rd_addr = 7'd0; tick();
      total++;
      if (oob_err !== 1'b0 || rd_valid !== 1'b1 || rd_data !== model[0]) begin
         bad++;
         $display("FAIL oob_after got oob=%b valid=%b data=%h exp 0 1 %h", oob_err, rd_valid, rd_data, model[0]);
      end
      idle_inputs(); tick();
      last_rd = model[0];
   endtask

   task automatic test_clear;
      int cnt;
      for (int a = 0; a < DEPTH; a++) begin
         wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = 16'h00FF; tick();
      end
      idle_inputs(); clr_start = 1'b1; tick();
      clr_start = 1'b0;
      cnt = (busy === 1'b1) ? 1 : 0;
      wr_en = 1'b1; wr_addr = 7'd3; wr_data = 16'h7777; rd_en = 1'b1; rd_addr = 7'd3; tick();
      if (busy === 1'b1) cnt++;
      total++;
      if (rd_valid !== 1'b0 || oob_err !== 1'b0 || rd_data !== last_rd) begin
         bad++;
         $display("FAIL clear_port_ignored got valid=%b oob=%b data=%h exp 0 0 %h", rd_valid, oob_err, rd_data, last_rd);
      end
      idle_inputs(); clr_start = 1'b1; tick();
      if (busy === 1'b1) cnt++;
      clr_start = 1'b0;
      for (int i = 0; i < 200 && busy === 1'b1; i++) begin
         tick();
         if (busy === 1'b1) cnt++;
      end
      total++;
      if (cnt != DEPTH) begin
         bad++;
         $display("FAIL clear_busy_len got=%0d exp=%0d", cnt, DEPTH);
      end
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_en = 1'b1; rd_addr = ADDR_W'(a); tick();
         total++;
         if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL clear_read addr=%0d got valid=%b data=%h exp 1 0000", a, rd_valid, rd_data);
         end
      end
      idle_inputs(); tick();
      last_rd = '0;
   endtask

   task automatic test_reset_mid;
      int cnt;
      wr_en = 1'b1; wr_addr = 7'd7; wr_data = 16'h5555; tick();
      idle_inputs(); rd_en = 1'b1; rd_addr = 7'd7; rst = 1'b1; tick();
      rst = 1'b0; rd_en = 1'b0;
      total++;
      if (rd_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_access got valid=%b busy=%b exp 0 1", rd_valid, busy);
      end
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      cnt = (busy === 1'b1) ? 1 : 0;
      total++;
      if (rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_valid got=%b exp=0", rd_valid);
      end
      for (int i = 0; i < 200 && busy === 1'b1; i++) begin
         tick();
         if (busy === 1'b1) cnt++;
      end
      total++;
      if (cnt != DEPTH) begin
         bad++;
         $display("FAIL rst_mid_busy_len got=%0d exp=%0d", cnt, DEPTH);
      end
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      last_rd = '0;
   endtask

   task automatic test_random;
      logic              exp_valid, exp_oob, do_wr, do_rd;
      logic [ADDR_W-1:0] wa, ra;
      logic [DATA_W-1:0] wd, exp_data;
      int                errs;
      errs = 0;
      exp_data = last_rd;
      for (int n = 0; n < 400; n++) begin
         do_wr = ($urandom_range(0, 2) != 0);
         do_rd = ($urandom_range(0, 2) != 0);
         wa = ADDR_W'($urandom_range(0, 79));
         ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 79));
         wd = DATA_W'($urandom);
         wr_en = do_wr; wr_addr = wa; wr_data = wd; rd_en = do_rd; rd_addr = ra;
         exp_valid = do_rd;
         exp_oob = (do_wr && int'(wa) >= DEPTH) || (do_rd && int'(ra) >= DEPTH);
         if (do_rd) begin
            if (int'(ra) >= DEPTH) exp_data = '0;
`ifdef REGC_DP_BYPASS_EN
            else if (do_wr && wa == ra) exp_data = wd;
`endif
            else exp_data = model[ra];
         end
         if (do_wr && int'(wa) < DEPTH) model[wa] = wd;
         tick();
         total++;
         if (rd_valid !== exp_valid || oob_err !== exp_oob || rd_data !== exp_data) begin
            bad++;
            errs++;
            if (errs < 10)
               $display("FAIL random_%0d got valid=%b oob=%b data=%h exp %b %b %h", n, rd_valid, oob_err, rd_data, exp_valid, exp_oob, exp_data);
         end
      end
      idle_inputs(); tick();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_write_read();
      test_collision();
      test_oob();
      test_clear();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
